// File: rtl/packet_width_resampler.sv
// ============================================================================
// Module   : packet_width_resampler
// Purpose  : Dual-clock packet width converter. A packet of IN_WIDTH-bit words
//            is captured on clk_in into a single-packet buffer, then replayed
//            on clk_out as RATIO consecutive OUT_WIDTH-bit slices per word.
//            Short, overflowing, or busy-time packets are dropped and reported.
// Ports    : clk_in, rst_n, clk_out  - clocks and async active-low reset
//            enable_in, data_in      - clk_in packet input, one word per cycle
//            pkt_drop, drop_code     - clk_in drop pulse and held drop reason
//            rx_len, busy            - clk_in last accepted length, busy flag
//            enable_out, data_out    - clk_out slice stream
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module packet_width_resampler #(
  parameter int OUT_WIDTH  = 4,
  parameter int RATIO      = 2,
  parameter int ADDR_WIDTH = 11,
  parameter int MIN_LEN    = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      clk_out,
  input  logic                      enable_in,
  input  logic [OUT_WIDTH*RATIO-1:0] data_in,
  output logic                      pkt_drop,
  output logic [1:0]                drop_code,
  output logic [ADDR_WIDTH:0]       rx_len,
  output logic                      busy,
  output logic                      enable_out,
  output logic [OUT_WIDTH-1:0]      data_out
);

  localparam int IN_WIDTH = OUT_WIDTH * RATIO;
  localparam int DEPTH    = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   MIN_CNT    = (ADDR_WIDTH+1)'(MIN_LEN);
  localparam logic [2:0]            LAST_SLICE = 3'(RATIO - 1);

  // --------------------------------------------------------------------------
  // Packet buffer: write port on clk_in, registered read port on clk_out
  // --------------------------------------------------------------------------
  logic [IN_WIDTH-1:0]   mem [DEPTH];
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [IN_WIDTH-1:0]   rdata;

  always_ff @(posedge clk_in) begin
    if (we) mem[waddr] <= data_in;
  end

  always_ff @(posedge clk_out) begin
    if (rd_en) rdata <= mem[rd_addr];
  end

  // --------------------------------------------------------------------------
  // Write side (clk_in)
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    W_IDLE    = 3'd0,
    W_RECV    = 3'd1,
    W_CHECK   = 3'd2,
    W_REQ     = 3'd3,
    W_RELEASE = 3'd4
  } wstate_t;

  wstate_t               w_state, w_state_nx;
  logic [ADDR_WIDTH:0]   wcnt, wcnt_nx;
  logic                  ovf, ovf_nx;
  logic [ADDR_WIDTH:0]   len_reg, len_reg_nx;
  logic [ADDR_WIDTH:0]   rx_len_nx;
  logic                  req, req_nx;
  logic                  busy_nx;
  logic                  drop_nx;
  logic [1:0]            drop_code_nx;
  logic                  ignore, ignore_nx;   // swallowing the tail of a refused packet
  logic                  en_d;
  logic                  ack;
  logic                  ack_meta, ack_sync;
  logic                  busy_window;

  assign busy_window = (w_state == W_CHECK) || (w_state == W_REQ) || (w_state == W_RELEASE);

  always_comb begin
    w_state_nx   = w_state;
    wcnt_nx      = wcnt;
    ovf_nx       = ovf;
    len_reg_nx   = len_reg;
    rx_len_nx    = rx_len;
    req_nx       = req;
    busy_nx      = busy;
    drop_nx      = 1'b0;
    drop_code_nx = drop_code;
    ignore_nx    = ignore & enable_in;
    we           = 1'b0;
    waddr        = wcnt[ADDR_WIDTH-1:0];
    case (w_state)
      W_IDLE: begin
        if (enable_in && !ignore) begin
          we         = 1'b1;
          waddr      = '0;
          wcnt_nx    = CNT_ONE;
          ovf_nx     = 1'b0;
          w_state_nx = W_RECV;
        end
      end
      W_RECV: begin
        if (enable_in) begin
          // wcnt MSB set means the buffer already holds 2^ADDR_WIDTH words
          if (wcnt[ADDR_WIDTH]) begin
            ovf_nx = 1'b1;
          end else begin
            we      = 1'b1;
            wcnt_nx = wcnt + CNT_ONE;
          end
        end else begin
          w_state_nx = W_CHECK;
          // Drop pulse is registered here so it is visible during CHECK
          if (ovf) begin
            drop_nx      = 1'b1;
            drop_code_nx = 2'b10;
          end else if (wcnt < MIN_CNT) begin
            drop_nx      = 1'b1;
            drop_code_nx = 2'b01;
          end
        end
      end
      W_CHECK: begin
        if (ovf || (wcnt < MIN_CNT)) begin
          w_state_nx = W_IDLE;
        end else begin
          len_reg_nx = wcnt;
          rx_len_nx  = wcnt;
          req_nx     = 1'b1;
          busy_nx    = 1'b1;
          w_state_nx = W_REQ;
        end
      end
      W_REQ: begin
        if (ack_sync) begin
          req_nx     = 1'b0;
          w_state_nx = W_RELEASE;
        end
      end
      W_RELEASE: begin
        if (!ack_sync) begin
          busy_nx    = 1'b0;
          w_state_nx = W_IDLE;
        end
      end
      default: w_state_nx = W_IDLE;
    endcase

    // A packet starting while the buffer is owned is refused in full
    if (busy_window && enable_in && !en_d) begin
      drop_nx      = 1'b1;
      drop_code_nx = 2'b11;
      ignore_nx    = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      wcnt      <= '0;
      ovf       <= 1'b0;
      len_reg   <= '0;
      rx_len    <= '0;
      req       <= 1'b0;
      busy      <= 1'b0;
      pkt_drop  <= 1'b0;
      drop_code <= 2'b00;
      // Any packet in flight at reset is discarded up to its end
      ignore    <= 1'b1;
      en_d      <= 1'b0;
      ack_meta  <= 1'b0;
      ack_sync  <= 1'b0;
    end else begin
      w_state   <= w_state_nx;
      wcnt      <= wcnt_nx;
      ovf       <= ovf_nx;
      len_reg   <= len_reg_nx;
      rx_len    <= rx_len_nx;
      req       <= req_nx;
      busy      <= busy_nx;
      pkt_drop  <= drop_nx;
      drop_code <= drop_code_nx;
      ignore    <= ignore_nx;
      en_d      <= enable_in;
      ack_meta  <= ack;
      ack_sync  <= ack_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Read side (clk_out)
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_SEND  = 2'd2,
    R_ACK   = 2'd3
  } rstate_t;

  rstate_t               r_state, r_state_nx;
  logic                  req_meta, req_sync;
  logic [ADDR_WIDTH:0]   len_lat, len_lat_nx;
  logic [ADDR_WIDTH-1:0] raddr, raddr_nx;     // next word address to prefetch
  logic [ADDR_WIDTH:0]   word_cnt, word_cnt_nx;
  logic [2:0]            slice, slice_nx;     // slice index currently on data_out
  logic [IN_WIDTH-1:0]   cur_word, cur_word_nx;
  logic                  ack_nx;
  logic                  enable_out_nx;
  logic [OUT_WIDTH-1:0]  data_out_nx;
  logic [IN_WIDTH-1:0]   src_word;
  logic [2:0]            src_slice;
  logic [2:0]            slice_pos;
  logic [OUT_WIDTH-1:0]  slice_data;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign slice_pos = LAST_SLICE - src_slice;
    end else begin : g_lsb_first
      assign slice_pos = src_slice;
    end
  endgenerate

  always_comb begin
    slice_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (slice_pos == 3'(i)) slice_data = src_word[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_comb begin
    r_state_nx    = r_state;
    len_lat_nx    = len_lat;
    raddr_nx      = raddr;
    word_cnt_nx   = word_cnt;
    slice_nx      = slice;
    cur_word_nx   = cur_word;
    ack_nx        = ack;
    enable_out_nx = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = raddr;
    src_word      = cur_word;
    src_slice     = slice;
    case (r_state)
      R_IDLE: begin
        if (req_sync) begin
          len_lat_nx  = len_reg;
          rd_en       = 1'b1;
          rd_addr     = '0;
          raddr_nx    = ADDR_ONE;
          word_cnt_nx = '0;
          slice_nx    = '0;
          r_state_nx  = R_FETCH;
        end
      end
      R_FETCH: begin
        // Word 0 is now in rdata; present its first slice and prefetch word 1
        enable_out_nx = 1'b1;
        src_word      = rdata;
        src_slice     = '0;
        cur_word_nx   = rdata;
        rd_en         = 1'b1;
        raddr_nx      = raddr + ADDR_ONE;
        slice_nx      = '0;
        r_state_nx    = R_SEND;
      end
      R_SEND: begin
        if (slice != LAST_SLICE) begin
          enable_out_nx = 1'b1;
          src_slice     = slice + 3'd1;
          slice_nx      = slice + 3'd1;
        end else if (word_cnt == (len_lat - CNT_ONE)) begin
          ack_nx     = 1'b1;
          r_state_nx = R_ACK;
        end else begin
          // rdata already holds the next word, so the stream has no gap
          enable_out_nx = 1'b1;
          src_word      = rdata;
          src_slice     = '0;
          slice_nx      = '0;
          cur_word_nx   = rdata;
          word_cnt_nx   = word_cnt + CNT_ONE;
          rd_en         = 1'b1;
          raddr_nx      = raddr + ADDR_ONE;
        end
      end
      R_ACK: begin
        if (!req_sync) begin
          ack_nx     = 1'b0;
          r_state_nx = R_IDLE;
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
    data_out_nx = enable_out_nx ? slice_data : '0;
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= R_IDLE;
      req_meta   <= 1'b0;
      req_sync   <= 1'b0;
      len_lat    <= '0;
      raddr      <= '0;
      word_cnt   <= '0;
      slice      <= '0;
      cur_word   <= '0;
      ack        <= 1'b0;
      enable_out <= 1'b0;
      data_out   <= '0;
    end else begin
      r_state    <= r_state_nx;
      req_meta   <= req;
      req_sync   <= req_meta;
      len_lat    <= len_lat_nx;
      raddr      <= raddr_nx;
      word_cnt   <= word_cnt_nx;
      slice      <= slice_nx;
      cur_word   <= cur_word_nx;
      ack        <= ack_nx;
      enable_out <= enable_out_nx;
      data_out   <= data_out_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_packet_width_resampler.sv
// ============================================================================
// Module   : tb_packet_width_resampler
// Purpose  : Scoreboard bench for packet_width_resampler. Two instances share
//            the stimulus: instance A (ADDR_WIDTH=4, LSB slice first) and
//            instance B (ADDR_WIDTH=11, MSB slice first).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_packet_width_resampler;

  logic       clk_in = 1'b0;
  logic       clk_out = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable_in = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic        pkt_drop_a, busy_a, enable_out_a;
  logic [1:0]  drop_code_a;
  logic [4:0]  rx_len_a;
  logic [3:0]  data_out_a;
  logic        pkt_drop_b, busy_b, enable_out_b;
  logic [1:0]  drop_code_b;
  logic [11:0] rx_len_b;
  logic [3:0]  data_out_b;

  always #20 clk_in  = ~clk_in;
  always #8  clk_out = ~clk_out;

  packet_width_resampler #(
    .OUT_WIDTH(4), .RATIO(2), .ADDR_WIDTH(4), .MIN_LEN(8), .MSB_FIRST(1'b0)
  ) dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .clk_out(clk_out),
    .enable_in(enable_in), .data_in(data_in),
    .pkt_drop(pkt_drop_a), .drop_code(drop_code_a), .rx_len(rx_len_a),
    .busy(busy_a), .enable_out(enable_out_a), .data_out(data_out_a)
  );

  packet_width_resampler #(
    .OUT_WIDTH(4), .RATIO(2), .ADDR_WIDTH(11), .MIN_LEN(8), .MSB_FIRST(1'b1)
  ) dut_b (
    .clk_in(clk_in), .rst_n(rst_n), .clk_out(clk_out),
    .enable_in(enable_in), .data_in(data_in),
    .pkt_drop(pkt_drop_b), .drop_code(drop_code_b), .rx_len(rx_len_b),
    .busy(busy_b), .enable_out(enable_out_b), .data_out(data_out_b)
  );

  int total = 0;
  int bad   = 0;

  logic [3:0] sq_a[$], sq_b[$];   // expected slices
  int         lq_a[$], lq_b[$];   // expected enable_out run lengths
  logic [1:0] dq_a[$], dq_b[$];   // expected drop codes
  int         run_a = 0, run_b = 0;
  int         exp_rx_a = 0, exp_rx_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected replay of an accepted packet of words base, base+1, ...
  function automatic void expect_accept(input bit is_b, input int len, input int base);
    logic [7:0] w;
    for (int i = 0; i < len; i++) begin
      w = 8'(base + i);
      if (!is_b) begin
        sq_a.push_back(w[3:0]);
        sq_a.push_back(w[7:4]);
      end else begin
        sq_b.push_back(w[7:4]);
        sq_b.push_back(w[3:0]);
      end
    end
    if (!is_b) begin
      lq_a.push_back(2 * len);
      exp_rx_a = len;
    end else begin
      lq_b.push_back(2 * len);
      exp_rx_b = len;
    end
  endfunction

  task automatic send_packet(input int len, input int base);
    for (int i = 0; i < len; i++) begin
      @(posedge clk_in); #2;
      enable_in = 1'b1;
      data_in   = 8'(base + i);
    end
    @(posedge clk_in); #2;
    enable_in = 1'b0;
    data_in   = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (4) @(negedge clk_in);
    while ((busy_a || busy_b) && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    check({tag, "_busy_released"}, {30'd0, busy_a, busy_b}, 32'd0);
    repeat (4) @(negedge clk_out);
    check({tag, "_a_slices_left"}, sq_a.size(), 0);
    check({tag, "_b_slices_left"}, sq_b.size(), 0);
    check({tag, "_a_rx_len"}, rx_len_a, exp_rx_a);
    check({tag, "_b_rx_len"}, rx_len_b, exp_rx_b);
  endtask

  // Slice monitors (clk_out domain)
  always @(negedge clk_out) begin
    if (!rst_n) begin
      run_a = 0;
    end else if (enable_out_a) begin
      run_a++;
      if (sq_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_slice actual=%0h required=none at %0t", data_out_a, $time);
      end else begin
        check("a_slice", data_out_a, sq_a.pop_front());
      end
    end else begin
      check("a_idle_data", data_out_a, 0);
      if (run_a != 0) begin
        if (lq_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_run actual=%0d required=none", run_a);
        end else begin
          check("a_run_len", run_a, lq_a.pop_front());
        end
        run_a = 0;
      end
    end
  end

  always @(negedge clk_out) begin
    if (!rst_n) begin
      run_b = 0;
    end else if (enable_out_b) begin
      run_b++;
      if (sq_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_slice actual=%0h required=none at %0t", data_out_b, $time);
      end else begin
        check("b_slice", data_out_b, sq_b.pop_front());
      end
    end else begin
      check("b_idle_data", data_out_b, 0);
      if (run_b != 0) begin
        if (lq_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_run actual=%0d required=none", run_b);
        end else begin
          check("b_run_len", run_b, lq_b.pop_front());
        end
        run_b = 0;
      end
    end
  end

  // Drop monitors (clk_in domain)
  always @(negedge clk_in) begin
    if (rst_n && pkt_drop_a) begin
      if (dq_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_drop actual=%0b required=none", drop_code_a);
      end else begin
        check("a_drop_code", drop_code_a, dq_a.pop_front());
      end
    end
    if (rst_n && pkt_drop_b) begin
      if (dq_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_drop actual=%0b required=none", drop_code_b);
      end else begin
        check("b_drop_code", drop_code_b, dq_b.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_enable_out_a", enable_out_a, 0);
    check("rst_data_out_a",   data_out_a,   0);
    check("rst_pkt_drop_a",   pkt_drop_a,   0);
    check("rst_drop_code_a",  drop_code_a,  0);
    check("rst_rx_len_a",     rx_len_a,     0);
    check("rst_busy_a",       busy_a,       0);
    check("rst_enable_out_b", enable_out_b, 0);
    check("rst_data_out_b",   data_out_b,   0);
    check("rst_pkt_drop_b",   pkt_drop_b,   0);
    check("rst_drop_code_b",  drop_code_b,  0);
    check("rst_rx_len_b",     rx_len_b,     0);
    check("rst_busy_b",       busy_b,       0);
    @(negedge clk_in); #3 rst_n = 1'b1;
    repeat (3) @(negedge clk_in);

    // 8-word packet: A gives 0,1,1,1,...,7,1 ; B gives 1,0,1,1,...,1,7
    expect_accept(1'b0, 8, 'h10);
    expect_accept(1'b1, 8, 'h10);
    send_packet(8, 'h10);
    wait_idle("p8");

    // 5-word packet: too short for both
    dq_a.push_back(2'b01);
    dq_b.push_back(2'b01);
    send_packet(5, 'h20);
    repeat (4) @(negedge clk_in);
    check("short_busy_a", busy_a, 0);
    check("short_busy_b", busy_b, 0);
    wait_idle("short");

    // 17 words: overflow for A (depth 16), accepted by B
    dq_a.push_back(2'b10);
    expect_accept(1'b1, 17, 'h30);
    send_packet(17, 'h30);
    wait_idle("p17");

    // 16 words: exactly A's depth, accepted by both
    expect_accept(1'b0, 16, 'h40);
    expect_accept(1'b1, 16, 'h40);
    send_packet(16, 'h40);
    wait_idle("p16");

    // Packet arriving while busy is refused; first replay stays intact
    expect_accept(1'b0, 8, 'h50);
    expect_accept(1'b1, 8, 'h50);
    send_packet(8, 'h50);
    n = 0;
    while (!(busy_a && busy_b) && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    check("busy_rise", {30'd0, busy_a, busy_b}, 32'd3);
    dq_a.push_back(2'b11);
    dq_b.push_back(2'b11);
    send_packet(8, 'h60);
    wait_idle("busy_first");
    expect_accept(1'b0, 9, 'h70);
    expect_accept(1'b1, 9, 'h70);
    send_packet(9, 'h70);
    wait_idle("busy_third");

    // Reset in the middle of a replay
    expect_accept(1'b0, 12, 'h80);
    expect_accept(1'b1, 12, 'h80);
    send_packet(12, 'h80);
    n = 0;
    while (!enable_out_a && n < 400) begin
      @(negedge clk_out);
      n++;
    end
    check("replay_started", enable_out_a, 1);
    repeat (5) @(negedge clk_out);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_enable_out_a", enable_out_a, 0);
    check("midrst_data_out_a",   data_out_a,   0);
    check("midrst_enable_out_b", enable_out_b, 0);
    check("midrst_data_out_b",   data_out_b,   0);
    check("midrst_busy_a",       busy_a,       0);
    check("midrst_rx_len_b",     rx_len_b,     0);
    sq_a.delete(); sq_b.delete();
    lq_a.delete(); lq_b.delete();
    dq_a.delete(); dq_b.delete();
    exp_rx_a = 0;
    exp_rx_b = 0;
    repeat (3) @(negedge clk_in);
    #3 rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    expect_accept(1'b0, 10, 'h90);
    expect_accept(1'b1, 10, 'h90);
    send_packet(10, 'h90);
    wait_idle("after_rst");

    check("a_runs_left", lq_a.size(), 0);
    check("b_runs_left", lq_b.size(), 0);
    check("a_drops_left", dq_a.size(), 0);
    check("b_drops_left", dq_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
